// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_flags buffering block.
package fifo_pkg;

  localparam int DEF_BUF_WIDTH = 2;
  localparam int DEF_PTR_W     = DEF_BUF_WIDTH + 1;
  localparam int DEF_AF_LEVEL  = (2 ** DEF_BUF_WIDTH) - 1;
  localparam int DEF_AE_LEVEL  = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Pointers carry one extra wrap bit above the memory address.
  function automatic int ptr_width(input int buf_width);
    return buf_width + 1;
  endfunction

endpackage

// File: rtl/fifo_flags_if.sv
// Producer/consumer port bundle for fifo_flags.
// i_we / i_re are requests sampled on the rising edge. There is no ready.
// A write is taken unless the FIFO is full with no read accepted alongside it.
// A read is taken unless the FIFO is empty.
// Refused requests raise the sticky o_overflow / o_underflow flags.
interface fifo_flags_if #(
  parameter int WIDTH     = 8,
  parameter int BUF_WIDTH = 2
);
  logic                 i_we;
  logic                 i_re;
  logic [WIDTH-1:0]     i_fifo;
  logic                 i_clr_err;
  logic [WIDTH-1:0]     o_fifo;
  logic [BUF_WIDTH:0]   o_count;
  logic                 o_empty;
  logic                 o_full;
  logic                 o_almost_empty;
  logic                 o_almost_full;
  logic                 o_overflow;
  logic                 o_underflow;

  modport master (
    output i_we, i_re, i_fifo, i_clr_err,
    input  o_fifo, o_count, o_empty, o_full, o_almost_empty, o_almost_full,
           o_overflow, o_underflow
  );

  modport slave (
    input  i_we, i_re, i_fifo, i_clr_err,
    output o_fifo, o_count, o_empty, o_full, o_almost_empty, o_almost_full,
           o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array. The read port is registered by default.
// It becomes combinational when FIFO_FWFT_EN is defined.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  logic unused_rd_ctrl;
  assign unused_rd_ctrl = &{1'b0, rst_n, re};
  assign rdata = mem[raddr];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/fifo_flags.sv
// Parametrised synchronous FIFO with fill count, thresholds and sticky error flags.
// The optional macro FIFO_FWFT_EN selects first-word fall-through read data.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BUF_WIDTH = DEF_BUF_WIDTH,
  parameter int AF_LEVEL  = (2 ** BUF_WIDTH) - 1,
  parameter int AE_LEVEL  = DEF_AE_LEVEL
) (
  input logic          i_clk,
  input logic          i_rst_n,
  fifo_flags_if.slave  bus
);

  localparam int PTR_W = ptr_width(BUF_WIDTH);
  localparam int DEPTH = 2 ** BUF_WIDTH;
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, count_q;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic             empty_q, full_q, almost_empty_q, almost_full_q;
  logic             overflow_q, underflow_q;
  logic             rd_ok, wr_ok;

  always_comb begin
    rd_ok      = bus.i_re & ~empty_q;
    // A write into a full FIFO only fits if a word leaves on the same edge.
    wr_ok      = bus.i_we & (~full_q | rd_ok);
    wr_ptr_nxt = wr_ptr + PTR_W'(wr_ok);
    rd_ptr_nxt = rd_ptr + PTR_W'(rd_ok);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      count_q        <= count_nxt;
      empty_q        <= (count_nxt == '0);
      full_q         <= (count_nxt == DEPTH_C);
      almost_empty_q <= (count_nxt <= AE_C);
      almost_full_q  <= (count_nxt >= AF_C);
      // A new error on the same edge as a clear keeps the flag set.
      overflow_q     <= (bus.i_we & ~wr_ok) | (overflow_q  & ~bus.i_clr_err);
      underflow_q    <= (bus.i_re & ~rd_ok) | (underflow_q & ~bus.i_clr_err);
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (BUF_WIDTH)
  ) u_mem (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (wr_ok),
    .waddr (wr_ptr[BUF_WIDTH-1:0]),
    .wdata (bus.i_fifo),
    .re    (rd_ok),
    .raddr (rd_ptr[BUF_WIDTH-1:0]),
    .rdata (bus.o_fifo)
  );

  assign bus.o_count        = count_q;
  assign bus.o_empty        = empty_q;
  assign bus.o_full         = full_q;
  assign bus.o_almost_empty = almost_empty_q;
  assign bus.o_almost_full  = almost_full_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_flags.sv
// Randomised scoreboard bench for fifo_flags (WIDTH=3, DEPTH=4, AF=3, AE=1).
module tb_fifo_flags;

  localparam int W     = 3;
  localparam int BW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  typedef struct packed {
    logic [W-1:0] data;
    logic [BW:0]  count;
    logic         empty;
    logic         full;
    logic         ae;
    logic         af;
    logic         ovf;
    logic         udf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  exp_t         exp_q[$];
  logic [W-1:0] model_q[$];
  logic         ovf_m, udf_m;
  logic [W-1:0] last_m;

  fifo_flags_if #(.WIDTH(W), .BUF_WIDTH(BW)) bus ();

  fifo_flags #(
    .WIDTH(W), .BUF_WIDTH(BW), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of at most DEPTH words.
  function automatic exp_t model_step(input logic we, input logic re,
                                      input logic [W-1:0] d, input logic clr);
    exp_t e;
    logic rd_acc, wr_acc;
    int   n;
    rd_acc = re && (model_q.size() > 0);
    wr_acc = we && ((model_q.size() < DEPTH) || rd_acc);
    ovf_m  = (we && !wr_acc) || (ovf_m && !clr);
    udf_m  = (re && !rd_acc) || (udf_m && !clr);
    if (rd_acc) last_m = model_q.pop_front();
    if (wr_acc) model_q.push_back(d);
    n       = model_q.size();
    e.count = (BW+1)'(n);
    e.empty = (n == 0);
    e.full  = (n == DEPTH);
    e.ae    = (n <= AE);
    e.af    = (n >= AF);
    e.ovf   = ovf_m;
    e.udf   = udf_m;
`ifdef FIFO_FWFT_EN
    e.data  = (n > 0) ? model_q[0] : '0;
`else
    e.data  = last_m;
`endif
    return e;
  endfunction

  // Driver: one request per clock edge, inputs changed 1 ns after the edge.
  task automatic cycle(input logic we, input logic re, input logic [W-1:0] d,
                       input logic clr = 1'b0);
    bus.i_we      = we;
    bus.i_re      = re;
    bus.i_fifo    = d;
    bus.i_clr_err = clr;
    @(posedge clk);
    exp_q.push_back(model_step(we, re, d, clr));
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_we = 1'b0; bus.i_re = 1'b0; bus.i_fifo = '0; bus.i_clr_err = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
    last_m = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, 32'(bus.o_count), 0);
    check({tag, "_empty"}, 32'(bus.o_empty), 1);
    check({tag, "_full"},  32'(bus.o_full), 0);
    check({tag, "_ae"},    32'(bus.o_almost_empty), 1);
    check({tag, "_af"},    32'(bus.o_almost_full), 0);
    check({tag, "_ovf"},   32'(bus.o_overflow), 0);
    check({tag, "_udf"},   32'(bus.o_underflow), 0);
`ifndef FIFO_FWFT_EN
    check({tag, "_data"},  32'(bus.o_fifo), 0);
`endif
  endtask

  // Asynchronous reset asserted between edges, checked before the next edge.
  task automatic mid_reset();
    @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    idle_inputs();
    #10;
    rst_n = 1'b1;
    #1;
  endtask

  // Monitor: pops one expectation per edge and compares on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("count", 32'(bus.o_count), 32'(e.count));
      check("empty", 32'(bus.o_empty), 32'(e.empty));
      check("full",  32'(bus.o_full), 32'(e.full));
      check("almost_empty", 32'(bus.o_almost_empty), 32'(e.ae));
      check("almost_full",  32'(bus.o_almost_full), 32'(e.af));
      check("overflow",  32'(bus.o_overflow), 32'(e.ovf));
      check("underflow", 32'(bus.o_underflow), 32'(e.udf));
`ifdef FIFO_FWFT_EN
      if (!e.empty) check("data", 32'(bus.o_fifo), 32'(e.data));
`else
      check("data", 32'(bus.o_fifo), 32'(e.data));
`endif
    end
  end

  initial begin
    int drain;
    model_reset();
    idle_inputs();
    rst_n = 1'b0;
    #100;
    check_reset_values("reset");
    #10;
    rst_n = 1'b1;

    // Fill then drain in order
    cycle(1, 0, 3'b101);
    cycle(1, 0, 3'b100);
    cycle(1, 0, 3'b010);
    cycle(1, 0, 3'b111);
    repeat (4) cycle(0, 1, '0);

    // Overflow at full, then clear
    cycle(1, 0, 3'b101);
    cycle(1, 0, 3'b100);
    cycle(1, 0, 3'b010);
    cycle(1, 0, 3'b111);
    cycle(1, 0, 3'b001);
    cycle(0, 0, '0, 1'b1);
    repeat (4) cycle(0, 1, '0);

    // Underflow; clear together with a fresh underflow keeps it set
    cycle(0, 1, '0);
    cycle(0, 1, '0, 1'b1);
    cycle(0, 0, '0, 1'b1);

    // Simultaneous read/write at count 2 across pointer wrap
    cycle(1, 0, 3'd6);
    cycle(1, 0, 3'd7);
    for (int i = 1; i <= 6; i++) cycle(1, 1, 3'(i));
    repeat (2) cycle(0, 1, '0);

    // Simultaneous read/write at full and at empty
    for (int i = 0; i < 4; i++) cycle(1, 0, 3'(i + 2));
    cycle(1, 1, 3'b011);
    repeat (4) cycle(0, 1, '0);
    cycle(1, 1, 3'b110);
    cycle(0, 1, '0, 1'b1);

    // Reset in the middle of a burst at count 3
    cycle(1, 0, 3'b001);
    cycle(1, 0, 3'b010);
    cycle(1, 0, 3'b011);
    mid_reset();
    cycle(1, 0, 3'b110);
    cycle(0, 1, '0);
    cycle(0, 0, '0);

    // Randomised phases with varying write/read bias
    for (int phase = 0; phase < 4; phase++) begin
      int wp, rp;
      wp = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
      rp = (phase == 0) ? 20 : (phase == 1) ? 80 : 50;
      for (int i = 0; i < 100; i++) begin
        cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
              3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
      end
      if (phase == 2) mid_reset();
    end
    idle_inputs();

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
Parametrised synchronous FIFO, successor to the basic fifo block. Adds:
- generic depth via BUF_WIDTH;
- fill count;
- programmable almost-full and almost-empty thresholds;
- full flag;
- sticky overflow/underflow error flags with clear;
- defined simultaneous read/write behaviour.

It sits between producer and consumer stages of the datapath as the standard buffering element.

Parameters:
WIDTH, 8, data word width in bits (>=1)
BUF_WIDTH, 2, log2 of depth; DEPTH = 2**BUF_WIDTH words
AF_LEVEL, DEPTH-1, o_almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, o_almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_we  in  1  write request
i_re  in  1  read request
i_fifo  in  WIDTH  write data
i_clr_err  in  1  clears o_overflow/o_underflow
o_fifo  out  WIDTH  read data
o_count  out  BUF_WIDTH+1  words stored (0..DEPTH)
o_empty  out  1  count == 0
o_full  out  1  count == DEPTH
o_almost_empty  out  1  count <= AE_LEVEL
o_almost_full  out  1  count >= AF_LEVEL
o_overflow  out  1  sticky: write rejected
o_underflow  out  1  sticky: read rejected

Behaviour:
Reset:
- One clock, i_clk; asynchronous active-low reset, i_rst_n.
- Reset asserted forces immediately, without a clock edge: pointers = 0, o_count = 0, o_empty = 1, o_full = 0, o_almost_empty = 1, o_almost_full = 0, o_overflow = 0, o_underflow = 0, o_fifo = 0.
- Storage array is not reset.

Pointers and count:
- wr_ptr and rd_ptr are BUF_WIDTH+1 bits each.
- The low BUF_WIDTH bits address memory; the MSB is the wrap bit.
- Both pointers wrap modulo 2*DEPTH.
- o_count is a register equal to wr_ptr - rd_ptr, computed modulo 2**(BUF_WIDTH+1).

Accept rules, evaluated at the rising edge:
- rd_ok = i_re & ~o_empty.
- wr_ok = i_we & (~o_full | rd_ok). Write while full is accepted only if a read is accepted in the same cycle.
- Empty with i_we & i_re: the write is accepted, the read is rejected and sets underflow.
- Count update: +1 on wr_ok only; -1 on rd_ok only; unchanged on both or neither.

Flags:
- All flags are registered and decoded from the next-state count, so they are valid in the same cycle as o_count.

Read data (default, registered):
- On rd_ok, o_fifo <= mem[rd_ptr], visible in the cycle after the read edge (latency 1).
- o_fifo holds its value when there is no accepted read.

Errors:
- o_overflow is set on i_we & ~wr_ok.
- o_underflow is set on i_re & ~rd_ok.
- Both flags stay set until i_clr_err.
- If a set condition and i_clr_err occur in the same cycle, set wins.
- Rejected accesses change neither pointers nor memory.

Reset mid-operation: all in-flight data is discarded; the first write after reset release lands at address 0.

Optional Feature:
FIFO_FWFT_EN
- Defined: first-word fall-through. o_fifo = mem[rd_ptr[BUF_WIDTH-1:0]], combinational from the array. The head word is valid whenever o_empty = 0, and i_re pops it. o_fifo is don't-care while empty. Accept rules and flags are unchanged.
- Undefined: registered read data with 1-cycle latency, as described above.

Decomposition:
- Shared package fifo_pkg holds: clog2 helper function, pointer-width localparam (BUF_WIDTH+1), and default threshold constants.
- One natural sub-module: fifo_mem, a simple dual-port register array.
  - Synchronous write port: we, waddr, wdata.
  - Read port: registered by default, combinational under FIFO_FWFT_EN.
- Pointer, count and flag logic stays in fifo_flags.

Test Plan:
All scenarios use WIDTH=3, BUF_WIDTH=2 (DEPTH 4), AF_LEVEL=3, AE_LEVEL=1, clock period 40 ns.
1. Reset: hold i_rst_n=0 for 100 ns -> o_empty=1, o_almost_empty=1, o_count=0, o_fifo=0, o_full=0, both error flags 0.
2. Fill: write 101, 100, 010, 111 on consecutive cycles.
   - o_almost_empty drops at count 2.
   - o_almost_full rises at count 3.
   - o_full=1 at count 4.
   Then read 4 cycles -> o_fifo = 101, 100, 010, 111, each one cycle after its read edge; finally o_empty=1.
3. Overflow: at full, write 001 -> o_overflow=1, o_count stays 4, subsequent reads still return 101 first. Pulse i_clr_err -> o_overflow=0.
4. Underflow: read when empty -> o_underflow=1, o_fifo holds its last value. Read plus i_clr_err in the same cycle -> o_underflow stays 1.
5. Simultaneous read/write:
   - At count 2, assert i_we & i_re for 6 cycles with data 1..6 -> o_count stays 2 and output order is preserved across pointer wrap.
   - At full, i_we & i_re -> both accepted, o_full stays 1, no overflow.
   - At empty, i_we & i_re -> o_count=1, o_underflow=1.
6. Async reset mid-burst: drop i_rst_n between clock edges at count 3 -> all outputs take their reset values before the next edge. Post-release write 110 then read -> 110.
